// File: rtl/alu_op_sequencer.sv
// Drives the 64-bit combinational ALU one op at a time, captures result/flags, owns the NZCV register.
// Latency: accept edge + 1 EXEC cycle -> rsp_valid (2 EXEC cycles when ALU_SEQ_SETTLE2_EN is defined).
// Backpressure: req_ready only in IDLE; RESP holds all response outputs until rsp_ready.
// Build option: define ALU_SEQ_SETTLE2_EN to give the ripple ALU a second settle cycle (EXEC1/EXEC2).
module alu_op_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [2:0]  req_op,
  input  logic        req_setflags,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [2:0]  alu_cntrl,
  input  logic [63:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_err,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

`ifdef ALU_SEQ_SETTLE2_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC1 = 2'd1, EXEC2 = 2'd2, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd3} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [63:0] hold_a;
  logic [63:0] hold_b;
  logic [2:0]  hold_op;
  logic        hold_setflags;
  logic [3:0]  nzcv_q;
  logic [3:0]  nzcv_upd;
  logic        last_exec;
  logic        op_legal;

  // Codes 110 and 111 are the only illegal ones.
  assign op_legal  = !(hold_op[2] && hold_op[1]);

`ifdef ALU_SEQ_SETTLE2_EN
  assign last_exec = (state == EXEC2);
`else
  assign last_exec = (state == EXEC);
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Holding registers feed the ALU directly so its inputs stay stable through EXEC.
  assign alu_a     = hold_a;
  assign alu_b     = hold_b;
  assign alu_cntrl = hold_op;

  assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef ALU_SEQ_SETTLE2_EN
        if (req_valid) state_nxt = EXEC1;
`else
        if (req_valid) state_nxt = EXEC;
`endif
      end
`ifdef ALU_SEQ_SETTLE2_EN
      EXEC1:   state_nxt = EXEC2;
      EXEC2:   state_nxt = RESP;
`else
      EXEC:    state_nxt = RESP;
`endif
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Candidate NZCV value: only ADD/SUB/AND with setflags touch it; everything else keeps it.
  always_comb begin
    nzcv_upd = nzcv_q;
    if (hold_setflags) begin
      case (hold_op)
        OP_ADD, OP_SUB: nzcv_upd = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
        OP_AND:         nzcv_upd = {alu_negative, alu_zero, 2'b00};
        default:        nzcv_upd = nzcv_q;
      endcase
    end
  end

  // Latch request on accept; capture response and flags on the final EXEC edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_a        <= '0;
      hold_b        <= '0;
      hold_op       <= '0;
      hold_setflags <= 1'b0;
      rsp_result    <= '0;
      rsp_err       <= 1'b0;
      nzcv_q        <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        hold_a        <= req_a;
        hold_b        <= req_b;
        hold_op       <= req_op;
        hold_setflags <= req_setflags;
      end
      if (last_exec) begin
        rsp_result <= op_legal ? alu_result : 64'd0;
        rsp_err    <= !op_legal;
        if (op_legal) nzcv_q <= nzcv_upd;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 64-bit ALU attached.
// Expected responses are computed from the request and queued at accept, popped when rsp_valid shows.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_SETTLE2_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [2:0]  req_op;
  logic        req_setflags;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [2:0]  alu_cntrl;
  logic [63:0] alu_result;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carry_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_err;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic [3:0]  nzcv;

  typedef struct packed {
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } alu_out_t;

  typedef struct packed {
    logic [63:0] res;
    logic        err;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] nzcv_model = 4'b0000;
  alu_out_t   alu_o;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_setflags(req_setflags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  assign nzcv = {flag_n, flag_z, flag_c, flag_v};

  // Behavioural ALU; illegal codes return a^b so a leaked result is visible.
  function automatic alu_out_t alu_ref(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    alu_out_t    o;
    logic [64:0] w;
    o = '0;
    case (op)
      3'd0: o.res = a & b;
      3'd1: o.res = a | b;
      3'd2: begin
        w = {1'b0, a} + {1'b0, b};
        o.res = w[63:0];
        o.c = w[64];
        o.v = (a[63] == b[63]) && (o.res[63] != a[63]);
      end
      3'd3: begin
        w = {1'b0, a} + {1'b0, ~b} + 65'd1;
        o.res = w[63:0];
        o.c = w[64];
        o.v = (a[63] != b[63]) && (o.res[63] != a[63]);
      end
      3'd4: o.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd5: o.res = ~(a | b);
      default: o.res = a ^ b;
    endcase
    o.n = o.res[63];
    o.z = (o.res == 64'd0);
    return o;
  endfunction

  always_comb begin
    alu_o         = alu_ref(alu_a, alu_b, alu_cntrl);
    alu_result    = alu_o.res;
    alu_negative  = alu_o.n;
    alu_zero      = alu_o.z;
    alu_carry_out = alu_o.c;
    alu_overflow  = alu_o.v;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; stall = cycles rsp_ready is held low once rsp_valid is seen.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        input logic sf, input int stall);
    alu_out_t   r;
    exp_t       e;
    int         lat;
    logic [3:0] pre;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_setflags = sf;
    rsp_ready = (stall == 0);
    @(posedge clk);
    r   = alu_ref(a, b, op);
    pre = nzcv_model;
    e.err = (op > 3'd5);
    e.res = e.err ? 64'd0 : r.res;
    if (!e.err && sf) begin
      if (op == 3'd2 || op == 3'd3) nzcv_model = {r.n, r.z, r.c, r.v};
      else if (op == 3'd0)          nzcv_model = {r.n, r.z, 2'b00};
    end
    e.nzcv = nzcv_model;
    sb.push_back(e);
    @(negedge clk);
    // Scramble the request bus so any reliance on it after accept shows up.
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = op ^ 3'b001; req_setflags = ~sf;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
      check("alu_cntrl", alu_cntrl, op);
      check("req_ready_busy", req_ready, 0);
      check("nzcv_early", nzcv, pre);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, EXP_LAT);
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else e = sb.pop_front();
    check("rsp_result", rsp_result, e.res);
    check("rsp_err", rsp_err, e.err);
    check("nzcv", nzcv, e.nzcv);
    check("req_ready_resp", req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_result", rsp_result, e.res);
      check("stall_err", rsp_err, e.err);
      check("stall_nzcv", nzcv, e.nzcv);
      check("stall_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("req_ready_after", req_ready, 1);
    check("rsp_valid_after", rsp_valid, 0);
    check("nzcv_after", nzcv, e.nzcv);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    // Reset with handshakes asserted: reset must win.
    reset = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
    req_a = 64'h1234; req_b = 64'h5678; req_op = 3'd2; req_setflags = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_cntrl", alu_cntrl, 0);
    check("rst_nzcv", nzcv, 4'b0000);
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b1, 0);
    check("add_nzcv_0110", nzcv, 4'b0110);
    run_op(64'h8000_0000_0000_0000, 64'h1, 3'd3, 1'b1, 0);
    check("sub_nzcv_0011", nzcv, 4'b0011);
    run_op(64'h0F0F, 64'hF0F0, 3'd1, 1'b1, 0);
    check("or_keeps_nzcv", nzcv, 4'b0011);
    run_op(64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b1, 5);
    check("and_nzcv_1000", nzcv, 4'b1000);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b1, 0);
    check("setup_nzcv_1010", nzcv, 4'b1010);
    run_op(64'h1111, 64'h2222, 3'b110, 1'b1, 1);
    check("illegal6_nzcv", nzcv, 4'b1010);
    run_op(64'h0, 64'h0, 3'b111, 1'b1, 0);
    check("illegal7_nzcv", nzcv, 4'b1010);
    run_op(64'h5, 64'h5, 3'd3, 1'b0, 0);
    check("sub_noflags_nzcv", nzcv, 4'b1010);

    // Reset in the middle of EXEC drops the op and clears flags.
    check("pre_rst_req_ready", req_ready, 1);
    req_valid = 1'b1; req_a = 64'h1; req_b = 64'h1; req_op = 3'd3; req_setflags = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("in_exec", req_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nzcv_model = 4'b0000;
    check("midrst_nzcv", nzcv, 4'b0000);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    // Random mix through the scoreboard.
    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 4 == 0) ? ra : {$urandom, $urandom};
      run_op(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
